// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the instruction-fetch stage.
// It drives iFetch's reset/pc_src/branch_target, arbitrates trap/branch/jump
// redirects, defers redirects seen during a stall, and generates the IF/ID flush.
`ifndef WORD
`define WORD 32
`endif

module fetch_ctrl #(
  parameter int               WIDTH       = `WORD,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(60),
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cur_pc,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             trap,
  input  logic             halt_req,
  input  logic             resume,
  output logic             fetch_reset,
  output logic             pc_src,
  output logic [WIDTH-1:0] branch_target,
  output logic             flush,
  output logic             err,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_JMP  = 2'd1;
  localparam logic [1:0] LVL_BR   = 2'd2;
  localparam logic [1:0] LVL_TRAP = 2'd3;

  state_t           st_q, st_d;
  logic             pend_vld_q;
  logic [1:0]       pend_lvl_q;
  logic [WIDTH-1:0] pend_tgt_q;
  logic             pend_latch;
  logic             pend_clr;
  logic [CNT_W-1:0] cnt_q;
  logic             advance;

  logic [1:0]       br_lvl, jmp_lvl, new_lvl, pend_lvl_eff;
  logic [WIDTH-1:0] br_tgt, jmp_tgt, new_tgt, eff_tgt;
  logic             br_mis, jmp_mis, new_mis;
  logic             use_new, eff_vld;

  function automatic logic misaligned(input logic [WIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Candidate redirects: misaligned targets become a trap-level redirect to
  // the trap vector; equal levels among new inputs prefer trap, then branch.
  always_comb begin
    br_lvl  = LVL_NONE;
    br_tgt  = br_target;
    br_mis  = 1'b0;
    jmp_lvl = LVL_NONE;
    jmp_tgt = jmp_target;
    jmp_mis = 1'b0;
    if (br_taken) begin
      if (misaligned(br_target)) begin
        br_lvl = LVL_TRAP;
        br_tgt = TRAP_VECTOR;
        br_mis = 1'b1;
      end else begin
        br_lvl = LVL_BR;
      end
    end
    if (jmp_valid) begin
      if (misaligned(jmp_target)) begin
        jmp_lvl = LVL_TRAP;
        jmp_tgt = TRAP_VECTOR;
        jmp_mis = 1'b1;
      end else begin
        jmp_lvl = LVL_JMP;
      end
    end
    if (trap) begin
      new_lvl = LVL_TRAP;
      new_tgt = TRAP_VECTOR;
      new_mis = 1'b0;
    end else if (br_lvl != LVL_NONE && br_lvl >= jmp_lvl) begin
      new_lvl = br_lvl;
      new_tgt = br_tgt;
      new_mis = br_mis;
    end else begin
      new_lvl = jmp_lvl;
      new_tgt = jmp_tgt;
      new_mis = jmp_mis;
    end
    // A new redirect beats a stored one of equal level.
    pend_lvl_eff = pend_vld_q ? pend_lvl_q : LVL_NONE;
    use_new      = (new_lvl != LVL_NONE) && (new_lvl >= pend_lvl_eff);
    eff_vld      = use_new || pend_vld_q;
    eff_tgt      = use_new ? new_tgt : pend_tgt_q;
  end

  // Next state and iFetch controls; "hold" means reload cur_pc.
  always_comb begin
    st_d          = st_q;
    fetch_reset   = 1'b0;
    pc_src        = 1'b0;
    branch_target = '0;
    flush         = 1'b0;
    err           = 1'b0;
    pend_latch    = 1'b0;
    pend_clr      = 1'b0;
    advance       = 1'b0;
    if (reset) begin
      fetch_reset = 1'b1;
      flush       = 1'b1;
      st_d        = S_INIT;
    end else begin
      unique case (st_q)
        S_INIT: begin
          fetch_reset = 1'b1;
          flush       = 1'b1;
          st_d        = S_RUN;
        end
        S_RUN: begin
          if (stall) begin
            pc_src        = 1'b1;
            branch_target = cur_pc;
            pend_latch    = use_new;
            err           = use_new && new_mis;
            st_d          = S_STALL;
          end else if (eff_vld) begin
            pc_src        = 1'b1;
            branch_target = eff_tgt;
            flush         = 1'b1;
            err           = use_new && new_mis;
            advance       = 1'b1;
          end else if (halt_req) begin
            pc_src        = 1'b1;
            branch_target = cur_pc;
            st_d          = S_HALT;
          end else begin
            advance = 1'b1;
          end
        end
        S_STALL: begin
          if (stall) begin
            pc_src        = 1'b1;
            branch_target = cur_pc;
            pend_latch    = use_new;
            err           = use_new && new_mis;
          end else begin
            if (eff_vld) begin
              pc_src        = 1'b1;
              branch_target = eff_tgt;
              flush         = 1'b1;
              err           = use_new && new_mis;
            end
            advance  = 1'b1;
            pend_clr = 1'b1;
            st_d     = S_RUN;
          end
        end
        S_HALT: begin
          pc_src = 1'b1;
          if (trap) begin
            branch_target = TRAP_VECTOR;
            flush         = 1'b1;
            advance       = 1'b1;
            st_d          = S_RUN;
          end else begin
            branch_target = cur_pc;
            if (resume) st_d = S_RUN;
          end
        end
        default: st_d = S_INIT;
      endcase
    end
  end

  // State, pending-redirect control and fetch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= S_INIT;
      pend_vld_q <= 1'b0;
      pend_lvl_q <= LVL_NONE;
      cnt_q      <= '0;
    end else begin
      st_q <= st_d;
      if (pend_clr) begin
        pend_vld_q <= 1'b0;
        pend_lvl_q <= LVL_NONE;
      end else if (pend_latch) begin
        pend_vld_q <= 1'b1;
        pend_lvl_q <= new_lvl;
      end
      if (advance) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Pending target is data; its valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (pend_latch) pend_tgt_q <= new_tgt;
  end

  assign fetch_count = cnt_q;
  assign state       = st_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: an iFetch-like PC register closes the loop, a
// reference model predicts each cycle's outputs into a scoreboard, and a
// monitor compares on the falling edge.
module tb_fetch_ctrl;
  localparam int             W  = 32;
  localparam int             CW = 16;
  localparam logic [W-1:0]   TV = 32'd60;
  localparam int M_INIT = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, stall = 1'b0, br_taken = 1'b0, jmp_valid = 1'b0;
  logic          trap = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [W-1:0]  br_target = '0, jmp_target = '0, cur_pc = '0;
  logic          fetch_reset, pc_src, flush, err;
  logic [W-1:0]  branch_target;
  logic [CW-1:0] fetch_count;
  logic [1:0]    state;

  fetch_ctrl #(.WIDTH(W), .TRAP_VECTOR(TV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cur_pc(cur_pc), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jmp_valid(jmp_valid),
    .jmp_target(jmp_target), .trap(trap), .halt_req(halt_req), .resume(resume),
    .fetch_reset(fetch_reset), .pc_src(pc_src), .branch_target(branch_target),
    .flush(flush), .err(err), .fetch_count(fetch_count), .state(state)
  );

  // iFetch stand-in
  always @(posedge clk) begin
    if (fetch_reset)  cur_pc <= '0;
    else if (pc_src)  cur_pc <= branch_target;
    else              cur_pc <= cur_pc + 32'd4;
  end

  typedef struct {
    logic         fr, ps, fl, er;
    logic [W-1:0] bt;
    logic [1:0]   st;
    logic [CW-1:0] cnt;
    logic [W-1:0] pc;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int           m_mode = M_INIT;
  int           m_plvl = 0;
  logic [W-1:0] m_ptgt = '0;
  int           m_cnt  = 0;
  logic [W-1:0] m_pc   = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of the reference model using the currently driven inputs.
  task automatic model_step();
    exp_t         e;
    int           lv[3];
    logic [W-1:0] tg[3];
    logic         ms[3];
    int           nl, act;   // act: 0 increment, 1 hold, 2 redirect
    logic [W-1:0] nt, et;
    logic         nm, take_new, have;
    lv[0] = trap ? 3 : 0;  tg[0] = TV;  ms[0] = 1'b0;
    lv[1] = 0; tg[1] = br_target; ms[1] = 1'b0;
    if (br_taken) begin
      if (br_target % 4 != 0) begin lv[1] = 3; tg[1] = TV; ms[1] = 1'b1; end
      else lv[1] = 2;
    end
    lv[2] = 0; tg[2] = jmp_target; ms[2] = 1'b0;
    if (jmp_valid) begin
      if (jmp_target % 4 != 0) begin lv[2] = 3; tg[2] = TV; ms[2] = 1'b1; end
      else lv[2] = 1;
    end
    nl = 0; nt = '0; nm = 1'b0;
    for (int i = 0; i < 3; i++)
      if (lv[i] > nl) begin nl = lv[i]; nt = tg[i]; nm = ms[i]; end
    take_new = (nl > 0) && (nl >= m_plvl);
    have     = take_new || (m_plvl > 0);
    et       = take_new ? nt : m_ptgt;

    e.fr = 1'b0; e.ps = 1'b0; e.fl = 1'b0; e.er = 1'b0; e.bt = '0;
    e.st = 2'(m_mode); e.cnt = CW'(m_cnt); e.pc = m_pc;
    act = 0;
    if (reset) begin
      e.fr = 1'b1; e.fl = 1'b1;
      m_mode = M_INIT; m_plvl = 0; m_cnt = 0; m_pc = '0;
      act = -1;
    end else if (m_mode == M_INIT) begin
      e.fr = 1'b1; e.fl = 1'b1; m_mode = M_RUN; m_pc = '0; act = -1;
    end else if (m_mode == M_RUN || m_mode == M_STALL) begin
      if (stall) begin
        act = 1;
        if (take_new) begin m_plvl = nl; m_ptgt = nt; e.er = nm; end
        m_mode = M_STALL;
      end else if (have) begin
        act = 2; e.er = take_new && nm;
        m_plvl = 0; m_mode = M_RUN;
      end else if (halt_req && m_mode == M_RUN) begin
        act = 1; m_mode = M_HALT;
      end else begin
        act = 0; m_plvl = 0; m_mode = M_RUN;
      end
    end else begin
      if (trap) begin act = 2; et = TV; m_mode = M_RUN; end
      else begin act = 1; if (resume) m_mode = M_RUN; end
    end
    if (act == 0) begin
      m_pc = m_pc + 32'd4; m_cnt = (m_cnt + 1) % (1 << CW);
    end else if (act == 1) begin
      e.ps = 1'b1; e.bt = m_pc;
    end else if (act == 2) begin
      e.ps = 1'b1; e.bt = et; e.fl = 1'b1;
      m_pc = et; m_cnt = (m_cnt + 1) % (1 << CW);
    end
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic s, input logic b, input logic [W-1:0] bt_,
                     input logic j, input logic [W-1:0] jt, input logic tp,
                     input logic h, input logic rs);
    @(posedge clk); #1;
    reset = r; stall = s; br_taken = b; br_target = bt_; jmp_valid = j;
    jmp_target = jt; trap = tp; halt_req = h; resume = rs;
    model_step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic reset_then_idle(input int n);
    cyc(1, 0, 0, '0, 0, '0, 0, 0, 0);
    for (int i = 0; i < n; i++) idle();
  endtask

  function automatic logic [W-1:0] rand_tgt();
    logic [W-1:0] t;
    t = W'($urandom_range(0, 255));
    if ($urandom_range(0, 5) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("fetch_reset",   W'(fetch_reset), W'(e.fr));
        chk("pc_src",        W'(pc_src),      W'(e.ps));
        chk("branch_target", branch_target,   e.bt);
        chk("flush",         W'(flush),       W'(e.fl));
        chk("err",           W'(err),         W'(e.er));
        chk("state",         W'(state),       W'(e.st));
        chk("fetch_count",   W'(fetch_count), W'(e.cnt));
        chk("cur_pc",        cur_pc,          e.pc);
      end
    end
  end

  // stimulus
  initial begin
    repeat (2) @(posedge clk);
    // reset release and counting from zero
    reset_then_idle(4);
    cyc(0, 0, 1, 32'd44, 0, '0, 0, 0, 0);
    #1;
    chk("t1_pc", cur_pc, 32'd12);
    chk("t1_cnt", W'(fetch_count), 32'd3);
    chk("t2_pc_src", W'(pc_src), 32'd1);
    chk("t2_bt", branch_target, 32'd44);
    chk("t2_flush", W'(flush), 32'd1);
    idle(); #1; chk("t2_pc44", cur_pc, 32'd44);
    idle(); #1; chk("t2_pc48", cur_pc, 32'd48);
    // redirects during a stall
    reset_then_idle(4);
    cyc(0, 1, 0, '0, 1, 32'd32, 0, 0, 0); #1; chk("t3_bt_hold", branch_target, 32'd12);
    cyc(0, 1, 1, 32'd20, 0, '0, 0, 0, 0); #1; chk("t3_pc_hold", cur_pc, 32'd12);
    cyc(0, 1, 0, '0, 0, '0, 0, 0, 0);     #1; chk("t3_bt_hold2", branch_target, 32'd12);
    cyc(0, 0, 0, '0, 0, '0, 0, 0, 0);     #1;
    chk("t3_bt_rel", branch_target, 32'd20);
    chk("t3_flush", W'(flush), 32'd1);
    idle(); #1; chk("t3_pc20", cur_pc, 32'd20);
    idle(); #1; chk("t3_pc24", cur_pc, 32'd24);
    // priority and misalignment
    cyc(0, 0, 1, 32'd20, 0, '0, 1, 0, 0);
    idle(); #1; chk("t4_trap_pc", cur_pc, 32'd60);
    cyc(0, 0, 1, 32'd20, 1, 32'd32, 0, 0, 0);
    idle(); #1; chk("t4_br_over_jmp", cur_pc, 32'd20);
    cyc(0, 0, 1, 32'd22, 0, '0, 0, 0, 0); #1; chk("t4_err", W'(err), 32'd1);
    idle(); #1;
    chk("t4_err_drop", W'(err), 32'd0);
    chk("t4_mis_pc", cur_pc, 32'd60);
    // halt and resume
    reset_then_idle(3);
    cyc(0, 0, 0, '0, 0, '0, 0, 1, 0);
    idle(); #1; chk("t5_pc_hold", cur_pc, 32'd8); chk("t5_cnt", W'(fetch_count), 32'd2);
    idle();
    cyc(0, 0, 0, '0, 0, '0, 0, 0, 1); #1; chk("t5_cnt_frozen", W'(fetch_count), 32'd2);
    idle(); #1; chk("t5_pc8", cur_pc, 32'd8);
    idle(); #1; chk("t5_pc12", cur_pc, 32'd12);
    idle(); #1; chk("t5_pc16", cur_pc, 32'd16);
    // reset during a stall with a pending redirect
    cyc(0, 1, 1, 32'd20, 0, '0, 0, 0, 0);
    cyc(1, 1, 0, '0, 0, '0, 0, 0, 0);
    idle();
    idle(); #1; chk("t6_pc0", cur_pc, 32'd0); chk("t6_cnt0", W'(fetch_count), 32'd0);
    idle(); #1; chk("t6_pc4", cur_pc, 32'd4); chk("t6_cnt1", W'(fetch_count), 32'd1);
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, rand_tgt(),
          $urandom_range(0, 4) == 0, rand_tgt(),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 3) == 0);
    end
    @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drained", W'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Sits between the hazard unit, decode, execute and `iFetch`, and drives `iFetch`'s `reset`, `pc_src` and `branch_target` inputs. It holds the PC for the first cycle after reset, holds the PC during stalls and halts, and arbitrates redirects (trap, branch, jump). Redirects that arrive during a stall are latched and applied on release. It also generates the IF/ID flush.

## Interface

Parameters:
- `WIDTH`, default `` `WORD ``: PC/address width.
- `TRAP_VECTOR`, default `WIDTH'd60`: trap target address, word-aligned.
- `CNT_W`, default 16: width of the fetch counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cur_pc`  in  WIDTH  current PC from `iFetch`.
- `stall`  in  1  hazard unit requests PC hold.
- `br_taken`  in  1  execute-stage branch taken.
- `br_target`  in  WIDTH  branch target.
- `jmp_valid`  in  1  decode-stage jump.
- `jmp_target`  in  WIDTH  jump target.
- `trap`  in  1  trap request.
- `halt_req`  in  1  halt fetch.
- `resume`  in  1  leave halt.
- `fetch_reset`  out  1  to `iFetch` `reset`.
- `pc_src`  out  1  to `iFetch` `pc_src`.
- `branch_target`  out  WIDTH  to `iFetch` `branch_target`.
- `flush`  out  1  invalidate IF/ID register.
- `err`  out  1  misaligned-target pulse.
- `fetch_count`  out  CNT_W  count of PC updates.
- `state`  out  2  debug: INIT=0, RUN=1, STALL=2, HALT=3.

## Operation

- **Outputs.** `fetch_reset`, `pc_src`, `branch_target`, `flush` and `err` are combinational from state, pending register and inputs. `iFetch` samples them at the next edge.
- **Hold mechanism.** `pc_src=1`, `branch_target=cur_pc`.
- **Redirect levels.**
  - trap = 3, branch = 2, jump = 1.
  - The effective redirect is the highest level among new inputs and the pending register.
  - On a tie between a new input and the pending register, the new input wins.
- **Alignment.** A `br_target` or `jmp_target` with `[1:0]≠0` is replaced by `TRAP_VECTOR` and treated as level 3. `err=1` in that cycle only, and only when that source is selected.
- **Pending register.** Holds a valid bit, level (2 bits) and target (WIDTH). A new redirect overwrites it only if its level ≥ the stored level.
- **Reset.** While `reset=1`:
  - Next state is INIT; pending is cleared; `fetch_count=0`.
  - Outputs: `fetch_reset=1`, `pc_src=0`, `branch_target=0`, `flush=1`, `err=0`.
- **INIT.**
  - `fetch_reset=1`, `flush=1`; PC stays 0.
  - Lasts one cycle, then RUN; ignores all requests.
- **RUN.**
  - Redirect present, `stall=0`: `pc_src=1`, `branch_target`=selected target, `flush=1`; stay in RUN.
  - `stall=1`: hold; latch any redirect into pending; go to STALL.
  - `halt_req=1` with no redirect and `stall=0`: hold; go to HALT.
  - Otherwise: `pc_src=0`, and the PC increments.
- **STALL.**
  - While `stall=1`: hold, and keep latching redirects.
  - On `stall=0`: apply the effective redirect if one exists (`flush=1`), otherwise increment. Clear pending and go to RUN.
- **HALT.**
  - Hold every cycle.
  - `trap`: redirect to `TRAP_VECTOR`, `flush=1`, go to RUN.
  - `resume`: hold this cycle, go to RUN.
  - Branches and jumps are ignored.
- **Fetch counter.** `fetch_count` increments (modulo 2^CNT_W) on every edge where the PC neither holds nor is in reset/INIT. Redirects count.
- **Reset mid-operation.** Reset overrides everything: pending is discarded and the counter is zeroed.

## Timing

- Redirect latency: a redirect asserted in RUN with `stall=0` in cycle N gives `cur_pc`=target after edge N. `flush` is high in cycle N only.
- Deferred redirect: a redirect asserted during a stall is applied in the first cycle with `stall=0`. `cur_pc`=target one edge later.
- Reset release: in the first cycle after `reset` falls, `cur_pc=0` and `fetch_reset=1`. `cur_pc` then reads 0, 4, 8 on the next edges.
- Fetch counter: `fetch_count` updates on the same edge as the PC.
- Simultaneous `stall` and `halt_req` in RUN: the stall wins. `halt_req` must be re-asserted after the stall releases.

## Test plan

1. **Reset release.** Reset for 1 cycle, then release.
   - Required: one INIT cycle with `cur_pc=0`, then `cur_pc`=4, 8, 12; `fetch_count=3`.
2. **Branch in RUN.** At `cur_pc=12`, `br_taken=1`, `br_target=44` for 1 cycle.
   - Required: `pc_src=1`, `branch_target=44`, `flush=1` in that cycle; next `cur_pc`=44, then 48.
3. **Redirect during stall.** At `cur_pc=12`, `stall=1` for 3 cycles; `jmp_valid=1`, `jmp_target=32` in stall cycle 1; `br_taken=1`, `br_target=20` in stall cycle 2.
   - Required: `cur_pc` stays 12 with `branch_target=12`. On release, `branch_target=20` and `flush=1`; then `cur_pc`=20, 24.
4. **Priority and misalignment.**
   - Same cycle `trap=1` and `br_taken=1` (target 20): required `cur_pc`=60.
   - Same cycle `jmp_target=32` and `br_target=20`: required `cur_pc`=20.
   - `br_target=22`: required `err=1` for one cycle, then `cur_pc`=60.
5. **Halt and resume.** `halt_req` at `cur_pc=8`.
   - Required: `cur_pc` holds at 8 and `fetch_count` is frozen. Pulse `resume`: 8 holds one more cycle, then 12, 16.
6. **Reset mid-stall.** In STALL with pending target 20, assert `reset` for 1 cycle.
   - Required: pending is discarded; after INIT, `cur_pc`=0, 4; `fetch_count` restarts from 0.
